tick_scheduler: RTL and testbench
=================================

TICK_SCHEDULER -- requirements
Module: tick_scheduler

Interface
REQ-001 The module SHALL have parameter NUM_CH, default 4, meaning the number of independent tick channels (range 1..8).
REQ-002 The module SHALL have parameter WIDTH, default 32, meaning the period width in 50 MHz cycles.
REQ-003 The module SHALL have port Clock, input, 1 bit: the 50 MHz onboard clock, the only clock.
REQ-004 The module SHALL have port Reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port CfgWrite, input, 1 bit: a one-cycle strobe that writes CfgPeriod and CfgMode into channel CfgChan.
REQ-006 The module SHALL have port CfgChan, input, $clog2(NUM_CH) bits (minimum 1): the configuration target channel.
REQ-007 The module SHALL have port CfgPeriod, input, WIDTH bits: the tick period in Clock cycles.
REQ-008 The module SHALL have port CfgMode, input, 1 bit: 0 = one-shot, 1 = periodic.
REQ-009 The module SHALL have port Start, input, NUM_CH bits: a per-channel start/restart request, sampled each cycle.
REQ-010 The module SHALL have port Stop, input, NUM_CH bits: a per-channel stop request, sampled each cycle.
REQ-011 The module SHALL have port Tick, output, NUM_CH bits: a per-channel one-cycle pulse, registered.
REQ-012 The module SHALL have port Busy, output, NUM_CH bits: high while the channel is in RUN, registered.
REQ-013 The module SHALL have port Done, output, NUM_CH bits: sticky, set by one-shot completion and cleared by Start on that channel, registered.

Function
REQ-014 Each channel SHALL hold a period register, a mode register, a WIDTH-bit down-counter and a state in {IDLE, RUN}.
REQ-015 CfgWrite SHALL update only the addressed channel's period and mode registers; a CfgChan value >= NUM_CH SHALL be ignored.
REQ-016 A stored period of 0 SHALL behave as period 1.
REQ-017 Start in IDLE SHALL load the counter with period-1, enter RUN, set Busy and clear Done at the next edge.
REQ-018 Tick SHALL be high in exactly the cycle P cycles after the Start cycle (P=1: the cycle immediately after Start).
REQ-019 In RUN with counter > 0, the counter SHALL decrement by 1 per cycle.
REQ-020 In RUN with counter == 0, the channel SHALL pulse Tick for one cycle.
REQ-021 At that same counter == 0 point, periodic mode SHALL reload period-1 and stay in RUN, giving ticks exactly every P cycles.
REQ-022 At that same counter == 0 point, one-shot mode SHALL return to IDLE, clear Busy and set Done, all visible in the same cycle as Tick.
REQ-023 Start in RUN SHALL restart the channel: reload period-1 with no Tick from the aborted count, even if the counter == 0 in that cycle.
REQ-024 Stop SHALL force IDLE at the next edge, clearing Busy, suppressing any Tick due that cycle and leaving Done unchanged.
REQ-025 When Start and Stop are both high on the same channel in the same cycle, Stop SHALL win.
REQ-026 A CfgWrite to a RUN channel SHALL not alter its current count; the new period and mode SHALL apply from the next reload.
REQ-027 A CfgWrite and Start on the same channel in the same cycle SHALL make the Start use the newly written period and mode.
REQ-028 Channels SHALL be fully independent, with no cross-channel coupling in Tick timing.
REQ-029 The counter SHALL never wrap: it SHALL not decrement below 0, and period 2^WIDTH-1 SHALL give a tick every 2^WIDTH-1 cycles.

Reset
REQ-030 Reset_n low SHALL immediately, without waiting for a Clock edge, clear all states to IDLE and clear the counters to 0.
REQ-031 Reset_n low SHALL immediately clear the periods to 0, the modes to one-shot, and Tick, Busy and Done to 0.
REQ-032 Reset asserted mid-count SHALL abort the count with no Tick.
REQ-033 After reset release, a channel SHALL produce no Tick until it receives a Start.

Verification
REQ-034 The bench SHALL cover: ch0 period 5, periodic, Start at cycle 10 -> Tick at cycles 15, 20, 25, ... with Busy=1 throughout.
REQ-035 The bench SHALL cover: ch1 period 3, one-shot, Start at cycle 0 -> a single Tick at cycle 3 with Busy falling and Done rising at cycle 3; a later Start clears Done.
REQ-036 The bench SHALL cover: ch2 period 0 and period 1, periodic -> Tick every cycle starting the cycle after Start.
REQ-037 The bench SHALL cover: ch0 running at period 4 with Stop and Start together on the cycle its Tick is due -> no Tick, Busy=0.
REQ-038 The bench SHALL cover: ch3 running at period 8, CfgWrite period 2 mid-count -> the current tick lands on the period-8 boundary, then ticks every 2 cycles.
REQ-039 The bench SHALL cover: all channels running, Reset_n pulsed low between edges -> all outputs drop to 0 before the next edge, and no Tick occurs after release without a Start.

Source files
------------

// File: rtl/tick_scheduler.sv
// Multi-channel tick generator: each channel counts a programmable period and
// emits one-cycle Tick pulses, either once (one-shot) or repeatedly (periodic).
module tick_scheduler #(
    parameter int NUM_CH = 4,
    parameter int WIDTH  = 32,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              CfgWrite,
    input  logic [CH_W-1:0]   CfgChan,
    input  logic [WIDTH-1:0]  CfgPeriod,
    input  logic              CfgMode,
    input  logic [NUM_CH-1:0] Start,
    input  logic [NUM_CH-1:0] Stop,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Busy,
    output logic [NUM_CH-1:0] Done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state_q  [NUM_CH];
    state_t            state_d  [NUM_CH];
    logic [WIDTH-1:0]  period_q [NUM_CH];
    logic [WIDTH-1:0]  period_d [NUM_CH];
    logic [WIDTH-1:0]  cnt_q    [NUM_CH];
    logic [WIDTH-1:0]  cnt_d    [NUM_CH];
    logic [NUM_CH-1:0] mode_q, mode_d;
    logic [NUM_CH-1:0] tick_q, tick_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic [NUM_CH-1:0] cfg_hit;

    function automatic logic [WIDTH-1:0] eff_period(input logic [WIDTH-1:0] p);
        return (p == '0) ? WIDTH'(1) : p;
    endfunction

    always_comb begin
        cfg_hit = '0;
        if (CfgWrite && (32'(CfgChan) < NUM_CH)) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (CfgChan == CH_W'(i)) begin
                    cfg_hit[i] = 1'b1;
                end
            end
        end
    end

    // cnt holds the number of edges left until the expiry edge, at which the
    // registered Tick becomes visible. A Start loads P-1 (its own edge counts
    // as one), an expiry reload loads P; a one-cycle period expires at once.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            period_d[i] = cfg_hit[i] ? CfgPeriod : period_q[i];
            mode_d[i]   = cfg_hit[i] ? CfgMode : mode_q[i];
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            tick_d[i]   = 1'b0;
            done_d[i]   = done_q[i];

            if (Stop[i]) begin
                state_d[i] = IDLE;
                cnt_d[i]   = '0;
            end else if (Start[i]) begin
                done_d[i] = 1'b0;
                if (eff_period(period_d[i]) == WIDTH'(1)) begin
                    tick_d[i] = 1'b1;
                    if (mode_d[i]) begin
                        state_d[i] = RUN;
                        cnt_d[i]   = WIDTH'(1);
                    end else begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        done_d[i]  = 1'b1;
                    end
                end else begin
                    state_d[i] = RUN;
                    cnt_d[i]   = eff_period(period_d[i]) - WIDTH'(1);
                end
            end else if (state_q[i] == RUN) begin
                if (cnt_q[i] <= WIDTH'(1)) begin
                    tick_d[i] = 1'b1;
                    if (mode_q[i]) begin
                        cnt_d[i] = eff_period(period_q[i]);
                    end else begin
                        state_d[i] = IDLE;
                        cnt_d[i]   = '0;
                        done_d[i]  = 1'b1;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] - WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= IDLE;
                period_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            mode_q <= '0;
            tick_q <= '0;
            done_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i]  <= state_d[i];
                period_q[i] <= period_d[i];
                cnt_q[i]    <= cnt_d[i];
            end
            mode_q <= mode_d;
            tick_q <= tick_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            Busy[i] = (state_q[i] == RUN);
        end
    end

    assign Tick = tick_q;
    assign Done = done_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Scoreboard bench for tick_scheduler: stimulus queues expected per-cycle
// Tick/Busy/Done values, a negedge monitor pops and compares them.
module tb_tick_scheduler;

    localparam int NUM_CH = 4;
    localparam int WIDTH  = 8;

    logic             Clock;
    logic             Reset_n;
    logic             CfgWrite;
    logic [1:0]       CfgChan;
    logic [WIDTH-1:0] CfgPeriod;
    logic             CfgMode;
    logic [3:0]       Start;
    logic [3:0]       Stop;
    logic [3:0]       Tick;
    logic [3:0]       Busy;
    logic [3:0]       Done;

    tick_scheduler #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) dut (
        .Clock    (Clock),
        .Reset_n  (Reset_n),
        .CfgWrite (CfgWrite),
        .CfgChan  (CfgChan),
        .CfgPeriod(CfgPeriod),
        .CfgMode  (CfgMode),
        .Start    (Start),
        .Stop     (Stop),
        .Tick     (Tick),
        .Busy     (Busy),
        .Done     (Done)
    );

    typedef struct {
        int         cyc;
        logic [3:0] tick;
        logic [3:0] bm;
        logic [3:0] b;
        logic [3:0] dm;
        logic [3:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mon_i;
    bit   mon_hit;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp_v);
        end
    endtask

    task automatic ex(input int c, input logic [3:0] t, input logic [3:0] bm,
                      input logic [3:0] b, input logic [3:0] dm, input logic [3:0] d);
        exp_t e;
        e.cyc = c; e.tick = t; e.bm = bm; e.b = b; e.dm = dm; e.d = d;
        exp_q.push_back(e);
    endtask

    task automatic next();
        @(posedge Clock);
        #1;
        CfgWrite = 1'b0;
        Start    = '0;
        Stop     = '0;
    endtask

    task automatic goto(input int c);
        while (cyc < c) next();
    endtask

    task automatic set_cfg(input int ch, input int p, input bit m);
        CfgWrite  = 1'b1;
        CfgChan   = 2'(ch);
        CfgPeriod = WIDTH'(p);
        CfgMode   = m;
    endtask

    // Monitor: any cycle without a queued expectation must show no Tick.
    always @(negedge Clock) begin
        mon_hit = 1'b0;
        mon_i   = 0;
        while (mon_i < exp_q.size()) begin
            if (exp_q[mon_i].cyc == cyc) begin
                chk($sformatf("tick@%0d", cyc), Tick, exp_q[mon_i].tick);
                chk($sformatf("busy@%0d", cyc), Busy & exp_q[mon_i].bm, exp_q[mon_i].b);
                chk($sformatf("done@%0d", cyc), Done & exp_q[mon_i].dm, exp_q[mon_i].d);
                mon_hit = 1'b1;
                exp_q.delete(mon_i);
            end else if (exp_q[mon_i].cyc < cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missed@%0d: got no check expected check at cycle %0d", cyc, exp_q[mon_i].cyc);
                exp_q.delete(mon_i);
            end else begin
                mon_i++;
            end
        end
        if (!mon_hit && Tick !== 4'b0000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_tick@%0d: got %b expected 0000", cyc, Tick);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s;
        int c;
        Reset_n   = 1'b0;
        CfgWrite  = 1'b0;
        CfgChan   = '0;
        CfgPeriod = '0;
        CfgMode   = 1'b0;
        Start     = '0;
        Stop      = '0;
        #12 Reset_n = 1'b1;
        next();

        // reset state, no ticks without Start
        ex(3, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        ex(4, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);

        // ch1 one-shot P3 and ch0 periodic P5
        goto(5);
        set_cfg(1, 3, 1'b0);
        next();
        set_cfg(0, 5, 1'b1);
        next();
        s = cyc;
        ex(s + 1,  4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
        ex(s + 3,  4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010);
        ex(s + 11, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(s + 15, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010);
        ex(s + 20, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(s + 25, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(s + 27, 4'b0000, 4'b0011, 4'b0010, 4'b0010, 4'b0000);
        ex(s + 29, 4'b0010, 4'b0011, 4'b0000, 4'b0010, 4'b0010);
        Start = 4'b0010;
        goto(s + 10);
        Start = 4'b0001;
        goto(s + 26);
        Stop  = 4'b0001;
        Start = 4'b0010;
        goto(s + 32);

        // ch2 period 0 (cfg + Start same cycle), then period 1
        c = cyc;
        set_cfg(2, 0, 1'b1);
        Start = 4'b0100;
        for (int k = 1; k <= 3; k++) ex(c + k, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        ex(c + 4, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        goto(c + 3);
        Stop = 4'b0100;
        goto(c + 6);
        set_cfg(2, 1, 1'b1);
        goto(c + 7);
        Start = 4'b0100;
        for (int k = 8; k <= 10; k++) ex(c + k, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000);
        ex(c + 11, 4'b0000, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        goto(c + 10);
        Stop = 4'b0100;
        goto(c + 13);

        // ch0 P4: Stop+Start at expiry, then Start-only restart at expiry
        c = cyc;
        set_cfg(0, 4, 1'b1);
        ex(c + 5,  4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(c + 9,  4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        ex(c + 16, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(c + 20, 4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(c + 23, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(c + 24, 4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        goto(c + 1);
        Start = 4'b0001;
        goto(c + 8);
        Stop  = 4'b0001;
        Start = 4'b0001;
        goto(c + 12);
        Start = 4'b0001;
        goto(c + 19);
        Start = 4'b0001;
        goto(c + 23);
        Stop  = 4'b0001;
        goto(c + 26);

        // ch3 P8 reconfigured to P2 mid-count
        c = cyc;
        set_cfg(3, 8, 1'b1);
        ex(c + 9,  4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        ex(c + 11, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        ex(c + 13, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        ex(c + 14, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        goto(c + 1);
        Start = 4'b1000;
        goto(c + 4);
        set_cfg(3, 2, 1'b1);
        goto(c + 13);
        Stop = 4'b1000;
        goto(c + 16);

        // ch1 maximum period 2^WIDTH-1, periodic
        c = cyc;
        set_cfg(1, 255, 1'b1);
        Start = 4'b0010;
        ex(c + 254, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
        ex(c + 255, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        ex(c + 510, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        ex(c + 511, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        goto(c + 510);
        Stop = 4'b0010;
        goto(c + 513);

        // all channels running, asynchronous reset pulse between edges
        set_cfg(0, 4, 1'b1);
        next();
        set_cfg(1, 6, 1'b1);
        next();
        set_cfg(2, 7, 1'b0);
        next();
        set_cfg(3, 9, 1'b1);
        next();
        c = cyc;
        Start = 4'b1111;
        ex(c + 2, 4'b0000, 4'b1111, 4'b1111, 4'b1111, 4'b0000);
        ex(c + 4, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(c + 6, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000);
        ex(c + 7, 4'b0100, 4'b0100, 4'b0000, 4'b0100, 4'b0100);
        ex(c + 8, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        ex(c + 9, 4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0000);
        goto(c + 12);
        #1;
        chk("pre_rst_tick", Tick, 4'b0011);
        chk("pre_rst_busy", Busy, 4'b1011);
        chk("pre_rst_done", Done, 4'b0100);
        #1 Reset_n = 1'b0;
        #1;
        chk("async_rst_tick", Tick, 4'b0000);
        chk("async_rst_busy", Busy, 4'b0000);
        chk("async_rst_done", Done, 4'b0000);
        #3 Reset_n = 1'b1;
        ex(c + 20, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        ex(c + 40, 4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b0000);
        goto(c + 42);

        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL pending: got %0d unchecked expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
